// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants and types.
// Codeword bit k-1 holds position ck; data bit 0 is d1.
package hamming_pkg;

  localparam int CW_LEN   = 7;
  localparam int DATA_LEN = 4;

  // 1-based codeword positions carrying d1..d4
  localparam int DATA_POS [DATA_LEN] = '{3, 5, 6, 7};

  typedef logic [CW_LEN-1:0]   cw_t;
  typedef logic [DATA_LEN-1:0] data_t;

endpackage

// File: rtl/hamming74_correct.sv
// Hamming(7,4) syndrome, single-bit correction and
// data extraction; purely combinational.
module hamming74_correct
  import hamming_pkg::*;
(
  input  cw_t   cw_i,
  output data_t data_o,
  output logic  err_o
);

  logic [2:0] syn;
  logic [2:0] flip;
  logic [2:0] idx;
  cw_t        fixed;

  // Syndrome names the 1-based position to invert
  always_comb begin
    syn[0] = cw_i[0] ^ cw_i[2] ^ cw_i[4] ^ cw_i[6];
    syn[1] = cw_i[1] ^ cw_i[2] ^ cw_i[5] ^ cw_i[6];
    syn[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6];
    flip   = syn - 3'd1;
    fixed  = cw_i;
    if (syn != 3'd0) begin
      fixed[flip] = ~cw_i[flip];
    end
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DATA_LEN; k++) begin
      idx       = 3'(DATA_POS[k] - 1);
      data_o[k] = fixed[idx];
    end
    err_o = (syn != 3'd0);
  end

endmodule

// File: rtl/hamming74_decoder.sv
// Serial Hamming(7,4) decoder: collects c1..c7,
// corrects, then drains d1..d4 one bit per cycle.
module hamming74_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             sync_i,
  output logic             data_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] corr_cnt_o
);

  localparam logic [2:0] LAST_POS  = 3'(CW_LEN - 1);
  localparam logic [2:0] DRAIN_LEN = 3'(DATA_LEN);

  logic [2:0]       bcnt_q, bcnt_d;
  cw_t              cw_q, cw_d;
  data_t            osr_q, osr_d;
  logic [2:0]       drain_q, drain_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] pos;
  logic       load;
  cw_t        cw_full;
  data_t      dec_data;
  logic       dec_err;

  // Place the incoming bit; sync forces position c1
  always_comb begin
    pos     = sync_i ? 3'd0 : bcnt_q;
    load    = valid_i && (pos == LAST_POS);
    cw_full = cw_q;
    cw_full[pos] = data_i;
    cw_d    = cw_q;
    bcnt_d  = bcnt_q;
    if (valid_i) begin
      cw_d   = cw_full;
      bcnt_d = (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
    end
  end

  hamming74_correct u_correct (
    .cw_i   (cw_full),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  // Output drain: a load restarts it, else shift
  always_comb begin
    osr_d   = osr_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (load) begin
      osr_d   = dec_data;
      drain_d = DRAIN_LEN;
      err_d   = dec_err;
      if (dec_err && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (drain_q != 3'd0) begin
      osr_d   = osr_q >> 1;
      drain_d = drain_q - 3'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      cw_q    <= '0;
      osr_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      cw_q    <= cw_d;
      osr_q   <= osr_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o    = (drain_q != 3'd0);
  assign data_o     = osr_q[0] & valid_o;
  assign err_o      = err_q;
  assign corr_cnt_o = cnt_q;

endmodule

// File: doc/hamming74_decoder.md
HAMMING74_DECODER -- requirements
Module: hamming74_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the corrected-codeword counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port data_i, input, 1, serial coded bit from the deinterleaver.
REQ-005 SHALL have port valid_i, input, 1, data_i is accepted on an edge where valid_i=1.
REQ-006 SHALL have port sync_i, input, 1, qualified by valid_i; marks the current bit as codeword bit c1.
REQ-007 SHALL have port data_o, output, 1, serial decoded data bit.
REQ-008 SHALL have port valid_o, output, 1, data_o is meaningful.
REQ-009 SHALL have port err_o, output, 1, the current codeword was corrected; high only during its d1 cycle.
REQ-010 SHALL have port corr_cnt_o, output, CNT_W, saturating count of corrected codewords.

Function
REQ-011 SHALL receive codewords serially, c1 first: positions 1..7 = p1 p2 d1 p3 d2 d3 d4.
REQ-012 SHALL keep a 3-bit input bit counter 0..6; it advances only on accepted bits and wraps 6->0.
REQ-013 SHALL treat an accepted bit with sync_i=1 as c1 regardless of counter; any partial codeword is discarded.
REQ-014 SHALL compute the syndrome on the 7th accepted bit: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s3=c4^c5^c6^c7, s=4*s3+2*s2+s1.
REQ-015 SHALL invert bit c(s) when s!=0, then extract d1..d4 = c3,c5,c6,c7.
REQ-016 SHALL load d1..d4 into a 4-bit output shift register on the edge accepting c7.
REQ-017 SHALL drive d1 on data_o, with valid_o=1, in the cycle after that edge; d2, d3, d4 follow one per cycle, 4 cycles total.
REQ-018 SHALL drive data_o, valid_o and err_o from registers only; no combinational input-to-output path.
REQ-019 SHALL drive valid_o=0 and data_o=0 when no decoded bit is pending.
REQ-020 SHALL assert err_o for the d1 cycle iff s!=0 for that codeword.
REQ-021 SHALL increment corr_cnt_o on the load edge when s!=0, and hold at 2^CNT_W-1.
REQ-022 SHALL tolerate gaps in valid_i; output drain is independent of valid_i.
REQ-023 SHALL let a new load overwrite and restart the output register if a drain is in progress (drain takes 4 cycles; a codeword takes at least 7, so this does not occur in legal traffic).
REQ-024 SHALL let sync_i during an output drain leave the drain unaffected.

Reset
REQ-025 SHALL clear on rst=1: bit counter, input shift register, output register and drain count, data_o, valid_o, err_o, and corr_cnt_o.
REQ-026 SHALL resume after reset release with the next accepted bit treated as c1.
REQ-027 SHALL abort a partial codeword or pending output on reset mid-operation, with no spurious valid_o.

Structure
REQ-028 SHALL place CW_LEN=7, DATA_LEN=4 and the data-position table {3,5,6,7} in a shared package, hamming_pkg.
REQ-029 SHALL isolate syndrome and correction in combinational sub-module hamming74_correct (7-bit in; 4-bit data and 1-bit err out).

Verification
REQ-030 SHALL cover: sync on c1, stream 0110011 -> data_o 1,0,1,1 on cycles +1..+4 after c7; err_o=0; corr_cnt_o=0.
REQ-031 SHALL cover: stream 0110111 (c5 flipped) -> s=5, data_o 1,0,1,1; err_o=1 on d1 cycle; corr_cnt_o=1.
REQ-032 SHALL cover: back-to-back codewords at valid_i=1 every cycle for 100 codewords with random single-bit errors -> all data recovered; corr_cnt_o equals injected count.
REQ-033 SHALL cover: sync_i at bit 4 of a codeword -> partial discarded; next 7 bits decode correctly; no extra valid_o pulses.
REQ-034 SHALL cover: CNT_W=2 with 5 corrected codewords -> corr_cnt_o saturates at 3.
REQ-035 SHALL cover: rst asserted two cycles after a load -> valid_o drops immediately; no remaining bits are emitted.
